// File: rtl/memory_log_reg.sv
// Circular access-log memory: appends records in arrival order, reads them back by age,
// handles overflow by overwrite or drop, and wipes all entries with a sequential clear.
module memory_log_reg #(
    parameter int unsigned WIDTH     = 17,
    parameter int unsigned DEPTH     = 512,
    parameter bit          OVERWRITE = 1'b1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             append,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    input  logic [AW-1:0]    idx,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             rerr,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             busy
);

    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_CLEAR = 1'b1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [0:0]       r_state,   w_state_nxt;
    logic [AW-1:0]    r_head,    w_head_nxt;
    logic [AW-1:0]    r_wr_ptr,  w_wr_ptr_nxt;
    logic [AW-1:0]    r_clr_ptr, w_clr_ptr_nxt;
    logic [AW:0]      r_count,   w_count_nxt;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rvalid, r_rerr, r_overflow, r_busy, r_full, r_empty;

    logic             w_mem_we;
    logic [AW-1:0]    w_mem_addr;
    logic [WIDTH-1:0] w_mem_wdata;
    logic             w_rd_fire, w_rd_ok, w_ovf;
    logic [AW:0]      w_sum;
    logic [AW-1:0]    w_rd_addr;

    function automatic logic [AW-1:0] f_wrap_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    // Age index to physical slot: (head + idx) mod DEPTH without a divider.
    always_comb begin
        w_sum     = {1'b0, r_head} + {1'b0, idx};
        w_rd_addr = (w_sum >= DEPTH_C) ? AW'(w_sum - DEPTH_C) : AW'(w_sum);
        w_rd_ok   = ({1'b0, idx} < r_count);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_head_nxt    = r_head;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_clr_ptr_nxt = r_clr_ptr;
        w_count_nxt   = r_count;
        w_mem_we      = 1'b0;
        w_mem_addr    = r_wr_ptr;
        w_mem_wdata   = wdata;
        w_rd_fire     = 1'b0;
        w_ovf         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_state_nxt   = S_CLEAR;
                    w_head_nxt    = '0;
                    w_wr_ptr_nxt  = '0;
                    w_count_nxt   = '0;
                    w_clr_ptr_nxt = '0;
                end else begin
                    if (append) begin
                        if (!r_full) begin
                            w_mem_we     = 1'b1;
                            w_wr_ptr_nxt = f_wrap_inc(r_wr_ptr);
                            w_count_nxt  = r_count + (AW+1)'(1);
                        end else begin
                            w_ovf = 1'b1;
                            // When full the write pointer sits on the oldest slot.
                            if (OVERWRITE) begin
                                w_mem_we     = 1'b1;
                                w_wr_ptr_nxt = f_wrap_inc(r_wr_ptr);
                                w_head_nxt   = f_wrap_inc(r_head);
                            end
                        end
                    end
                    w_rd_fire = rd_en;
                end
            end
            default: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_ptr;
                w_mem_wdata = '0;
                if (r_clr_ptr == LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_clr_ptr_nxt = '0;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + AW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_head     <= '0;
            r_wr_ptr   <= '0;
            r_clr_ptr  <= '0;
            r_count    <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_rerr     <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_head     <= w_head_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_clr_ptr  <= w_clr_ptr_nxt;
            r_count    <= w_count_nxt;
            r_rvalid   <= w_rd_fire;
            r_rerr     <= w_rd_fire & ~w_rd_ok;
            r_overflow <= w_ovf;
            r_busy     <= (w_state_nxt == S_CLEAR);
            r_full     <= (w_count_nxt == DEPTH_C);
            r_empty    <= (w_count_nxt == '0);
            if (w_rd_fire) begin
                r_rdata <= w_rd_ok ? r_mem[w_rd_addr] : '0;
            end
        end
    end

    // Storage array is intentionally not reset; count=0 hides stale words.
    always_ff @(posedge clk) begin
        if (!reset && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign rdata    = r_rdata;
    assign rvalid   = r_rvalid;
    assign rerr     = r_rerr;
    assign count    = r_count;
    assign full     = r_full;
    assign empty    = r_empty;
    assign overflow = r_overflow;
    assign busy     = r_busy;

endmodule

// File: doc/memory_log_reg.md
# memory_log_reg

Parametrised circular access-log memory for the DigiLock opening-record store, successor to the fixed 17×512 opening register. It appends records in arrival order, reads them back by age (index 0 = oldest), reports fill level, handles overflow by overwrite or drop, and wipes its contents with a sequential clear. It sits between the lock controller, which appends one record per opening event, and the admin/display path, which browses the log.

## Interface
- `WIDTH`, default 17: record width in bits.
- `DEPTH`, default 512: number of entries, any value ≥ 2, not required to be a power of two.
- `OVERWRITE`, default 1: 1 = when full, a new record replaces the oldest; 0 = when full, a new record is dropped.
- Local `AW = $clog2(DEPTH)`; counters are `AW+1` bits wide.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `clear` input 1: start a sequential wipe of all entries.
- `append` input 1: store `wdata` as the newest record.
- `wdata` input WIDTH: record to append.
- `rd_en` input 1: request a read of the entry at age index `idx`.
- `idx` input AW: age index; 0 = oldest, `count-1` = newest.
- `rdata` output WIDTH: registered read data, held between reads.
- `rvalid` output 1: one-cycle pulse, `rdata` updated.
- `rerr` output 1: driven with `rvalid`; set when `idx >= count`.
- `count` output AW+1: number of valid records.
- `full` / `empty` output 1: `count==DEPTH` / `count==0`.
- `overflow` output 1: one-cycle pulse on an append made while full (for both modes).
- `busy` output 1: high while a clear is in progress.

## Operation
- State machine `IDLE`/`CLEAR`. Priority order: `reset` > `clear` > `append`/`rd_en`.
- Reset sets state `IDLE`, `head`=0, `wr_ptr`=0, `count`=0, `rdata`=0, and `rvalid`/`rerr`/`overflow`/`busy`=0. Reset does not initialise the array. Stale contents are unreachable because `count`=0.
- **`clear` in `IDLE`:**
  - In the same edge, `head`, `wr_ptr` and `count` are set to 0 and the state goes to `CLEAR`.
  - In `CLEAR`, one cycle writes 0 to `mem[clr_ptr]`, with `clr_ptr` running 0…DEPTH-1. After the write to DEPTH-1 the state returns to `IDLE`.
  - `busy`=1 for exactly DEPTH cycles.
  - While busy, `append`, `rd_en` and `clear` are ignored: no state change and no pulses.
- **Append in `IDLE` when not full:**
  - `mem[wr_ptr] <= wdata`.
  - `wr_ptr` increments, with an explicit wrap from DEPTH-1 to 0.
  - `count` increments.
- **Append in `IDLE` when full:**
  - `overflow` pulses.
  - If `OVERWRITE=1`: write `mem[wr_ptr]` (which is the oldest slot), then advance both `wr_ptr` and `head` with wrap; `count` stays at DEPTH.
  - If `OVERWRITE=0`: no write and no pointer change.
- **Read in `IDLE`:**
  - Physical address = (`head`+`idx`) mod DEPTH, computed at AW+1 bits with a conditional subtract of DEPTH.
  - If `idx < count`: `rdata` takes the memory word and `rerr`=0.
  - Otherwise: `rdata`=0 and `rerr`=1.
  - `rvalid` pulses in both cases.
- **Append and read in the same cycle:**
  - The read uses the pre-edge `head`/`count` and old memory contents (read-before-write).
  - Example: when full with `OVERWRITE=1`, `idx=0` returns the record being overwritten.
- `reset` during `CLEAR` aborts the wipe and returns to `IDLE`. Array contents are then partially wiped but unreachable.

## Timing
- Append: `count`/`full`/`empty` reflect the append on the cycle after the edge that samples `append`. `overflow` pulses on that same cycle.
- Read latency is 1 cycle: `rd_en` sampled at edge N gives `rdata`/`rvalid`/`rerr` valid after edge N. `rdata` holds until the next accepted read or reset.
- Back-to-back reads every cycle are supported, with one result per cycle.
- Clear: `busy` rises after the sampling edge and stays high DEPTH cycles. The first accepted operation is on the edge after `busy` falls.
- `count`, `full`, `empty` and `busy` are registered.

## Test plan
- Reset, then append 5, 6, 7 → `count`=3, `empty`=0. Read `idx`=0,1,2 → `rdata`=5,6,7 with `rvalid` each cycle after the request. Read `idx`=3 → `rdata`=0, `rerr`=1.
- DEPTH=4, OVERWRITE=1: append 1..6 → `full`=1, `overflow` pulses on the appends of 5 and 6, and `idx` 0..3 reads 3,4,5,6.
- DEPTH=4, OVERWRITE=0: append 1..6 → `count`=4, `overflow` pulses twice, and reads return 1,2,3,4.
- Fill with 4 records, then assert `clear` → `busy` high for exactly DEPTH cycles, `count`=0, `append`/`rd_en` during busy ignored. After `busy` falls, append 9 and read `idx`=0 → 9.
- DEPTH=4, full with OVERWRITE=1: assert `append` (wdata=A) and `rd_en` (idx=0) in the same cycle → old oldest value returned. A following read of `idx`=3 → A.
- Assert `reset` midway through a clear → `busy`=0, `count`=0 next cycle, and a subsequent append/read round-trips correctly.
